// File: rtl/alu.sv
// Registered two-operand ALU: add, sub, AND, OR with a one-cycle result latency.
// Status flags are produced only when ALU_FLAGS_EN is defined; otherwise the flag ports are tied to 0.
module alu #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] entradaA,
   input  logic [WIDTH-1:0] entradaB,
   input  logic [1:0]       sel,
   output logic [WIDTH-1:0] out,
   output logic             zero,
   output logic             negative,
   output logic             carry,
   output logic             overflow
);

   localparam logic [1:0] SEL_ADD = 2'd0;
   localparam logic [1:0] SEL_SUB = 2'd1;
   localparam logic [1:0] SEL_AND = 2'd2;
   localparam logic [1:0] SEL_OR  = 2'd3;

   logic [WIDTH-1:0] w_result;
   logic [WIDTH-1:0] r_out;

   always_comb begin
      w_result = '0;
      case (sel)
         SEL_ADD: w_result = entradaA + entradaB;
         SEL_SUB: w_result = entradaA - entradaB;
         SEL_AND: w_result = entradaA & entradaB;
         SEL_OR:  w_result = entradaA | entradaB;
         default: w_result = '0;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_out <= '0;
      end else if (en) begin
         r_out <= w_result;
      end
   end

   assign out = r_out;

`ifdef ALU_FLAGS_EN
   logic [WIDTH:0] w_add_ext;
   logic [WIDTH:0] w_sub_ext;
   logic           w_sign_a;
   logic           w_sign_b;
   logic           w_sign_r;
   logic           w_zero;
   logic           w_carry;
   logic           w_overflow;
   logic           r_zero;
   logic           r_negative;
   logic           r_carry;
   logic           r_overflow;

   // The extra top bit of the widened sub is the unsigned borrow (A < B).
   assign w_add_ext = {1'b0, entradaA} + {1'b0, entradaB};
   assign w_sub_ext = {1'b0, entradaA} - {1'b0, entradaB};
   assign w_sign_a  = entradaA[WIDTH-1];
   assign w_sign_b  = entradaB[WIDTH-1];
   assign w_sign_r  = w_result[WIDTH-1];
   assign w_zero    = (w_result == '0);

   always_comb begin
      w_carry    = 1'b0;
      w_overflow = 1'b0;
      case (sel)
         SEL_ADD: begin
            w_carry    = w_add_ext[WIDTH];
            w_overflow = (w_sign_a == w_sign_b) && (w_sign_r != w_sign_a);
         end
         SEL_SUB: begin
            w_carry    = w_sub_ext[WIDTH];
            w_overflow = (w_sign_a != w_sign_b) && (w_sign_r != w_sign_a);
         end
         default: begin
            w_carry    = 1'b0;
            w_overflow = 1'b0;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         r_zero     <= 1'b1;
         r_negative <= 1'b0;
         r_carry    <= 1'b0;
         r_overflow <= 1'b0;
      end else if (en) begin
         r_zero     <= w_zero;
         r_negative <= w_sign_r;
         r_carry    <= w_carry;
         r_overflow <= w_overflow;
      end
   end

   assign zero     = r_zero;
   assign negative = r_negative;
   assign carry    = r_carry;
   assign overflow = r_overflow;
`else
   assign zero     = 1'b0;
   assign negative = 1'b0;
   assign carry    = 1'b0;
   assign overflow = 1'b0;
`endif

endmodule

// File: tb/tb_alu.sv
// Bench for alu: a behavioural model checked every cycle, plus directed vectors with literal expectations.
// Flag expectations follow ALU_FLAGS_EN the same way the design build does.
module tb_alu;

   localparam int W = 32;
`ifdef ALU_FLAGS_EN
   localparam bit FLAGS = 1'b1;
`else
   localparam bit FLAGS = 1'b0;
`endif

   logic         clk;
   logic         rst;
   logic         en;
   logic [W-1:0] entradaA;
   logic [W-1:0] entradaB;
   logic [1:0]   sel;
   logic [W-1:0] out;
   logic         zero;
   logic         negative;
   logic         carry;
   logic         overflow;

   int checks = 0;
   int errors = 0;

   alu #(.WIDTH(W)) dut (
      .clk(clk), .rst(rst), .en(en),
      .entradaA(entradaA), .entradaB(entradaB), .sel(sel),
      .out(out), .zero(zero), .negative(negative),
      .carry(carry), .overflow(overflow)
   );

   // clock / reset defaults
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      rst = 1'b0; en = 1'b0; entradaA = '0; entradaB = '0; sel = 2'd0;
   end

   // ---------------- behavioural model ----------------
   logic [W-1:0] m_out;
   logic         m_z, m_n, m_c, m_v;
   bit           m_valid = 1'b0;

   task automatic model_eval(input logic [W-1:0] a, input logic [W-1:0] b, input logic [1:0] s,
                             output logic [W-1:0] r, output logic c, output logic v);
      longint ua, ub, sa, sb, full;
      ua = longint'(a);
      ub = longint'(b);
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      c = 1'b0;
      v = 1'b0;
      case (s)
         2'd0: begin
            full = ua + ub;
            r = full[W-1:0];
            c = (full >= (64'sd1 <<< W));
            v = ((sa + sb) > ((64'sd1 <<< (W-1)) - 1)) || ((sa + sb) < -(64'sd1 <<< (W-1)));
         end
         2'd1: begin
            full = ua - ub;
            r = full[W-1:0];
            c = (ua < ub);
            v = ((sa - sb) > ((64'sd1 <<< (W-1)) - 1)) || ((sa - sb) < -(64'sd1 <<< (W-1)));
         end
         2'd2: r = a & b;
         default: r = a | b;
      endcase
   endtask

   task automatic cmp(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=0x%08h expected=0x%08h at %0t", name, act, exp, $time);
      end
   endtask

   // compare process: model advances on each edge, DUT checked 1 time unit later
   always @(posedge clk) begin
      logic [W-1:0] r;
      logic c, v;
      if (rst) begin
         m_out = '0; m_z = FLAGS; m_n = 1'b0; m_c = 1'b0; m_v = 1'b0;
         m_valid = 1'b1;
      end else if (en) begin
         model_eval(entradaA, entradaB, sel, r, c, v);
         m_out = r;
         m_z = FLAGS & (r == '0);
         m_n = FLAGS & r[W-1];
         m_c = FLAGS & c;
         m_v = FLAGS & v;
      end
      #1;
      if (m_valid) begin
         cmp("model_out", out, m_out);
         cmp("model_zero", {31'b0, zero}, {31'b0, m_z});
         cmp("model_negative", {31'b0, negative}, {31'b0, m_n});
         cmp("model_carry", {31'b0, carry}, {31'b0, m_c});
         cmp("model_overflow", {31'b0, overflow}, {31'b0, m_v});
      end
   end

   // ---------------- driver ----------------
   task automatic drive(input logic r, input logic e, input logic [W-1:0] a,
                        input logic [W-1:0] b, input logic [1:0] s);
      @(negedge clk);
      rst = r; en = e; entradaA = a; entradaB = b; sel = s;
      @(posedge clk);
      #2;
   endtask

   // literal expectation: out plus the four flags (flag values as they would be with flags built in)
   task automatic expect_lit(input string name, input logic [W-1:0] eo,
                             input logic ez, input logic en_, input logic ec, input logic ev);
      cmp({name, "_out"}, out, eo);
      cmp({name, "_flags"}, {28'b0, zero, negative, carry, overflow},
          {28'b0, FLAGS & ez, FLAGS & en_, FLAGS & ec, FLAGS & ev});
   endtask

   initial begin : watchdog
      #200000;
      errors++;
      $display("FAIL watchdog timeout at %0t", $time);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : stimulus
      repeat (2) @(posedge clk);
      // reset for two edges, then hold with en=0
      drive(1'b1, 1'b0, 32'd0, 32'd0, 2'd0);
      drive(1'b1, 1'b0, 32'd0, 32'd0, 2'd0);
      expect_lit("reset", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b0, 32'd123, 32'd4, 2'd0);
      expect_lit("hold_after_reset", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // four operations on the same operands
      drive(1'b0, 1'b1, 32'd5001, 32'd3001, 2'd0);
      expect_lit("add_5001", 32'd8002, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'd5001, 32'd3001, 2'd1);
      expect_lit("sub_5001", 32'd2000, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'd5001, 32'd3001, 2'd2);
      expect_lit("and_5001", 32'd905, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'd5001, 32'd3001, 2'd3);
      expect_lit("or_5001", 32'd7097, 1'b0, 1'b0, 1'b0, 1'b0);

      // hold: en=0 with changing inputs, plus a change mid-cycle
      drive(1'b0, 1'b0, 32'hFFFF_FFFF, 32'd1, 2'd0);
      entradaA = 32'd1; entradaB = 32'd2; sel = 2'd1;
      #2;
      expect_lit("hold_midcycle", 32'd7097, 1'b0, 1'b0, 1'b0, 1'b0);

      drive(1'b0, 1'b1, 32'd8006001, 32'd8002, 2'd0);
      expect_lit("add_big", 32'd8014003, 1'b0, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'd5, 32'd5, 2'd1);
      expect_lit("sub_equal", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // add boundaries
      drive(1'b0, 1'b1, 32'h7FFF_FFFF, 32'd1, 2'd0);
      expect_lit("add_ovf", 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 2'd0);
      expect_lit("add_carry", 32'd0, 1'b1, 1'b0, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 32'h8000_0000, 32'h8000_0000, 2'd0);
      expect_lit("add_negneg", 32'd0, 1'b1, 1'b0, 1'b1, 1'b1);

      // sub boundaries
      drive(1'b0, 1'b1, 32'h8000_0000, 32'd1, 2'd1);
      expect_lit("sub_ovf", 32'h7FFF_FFFF, 1'b0, 1'b0, 1'b0, 1'b1);
      drive(1'b0, 1'b1, 32'd1, 32'd2, 2'd1);
      expect_lit("sub_borrow", 32'hFFFF_FFFF, 1'b0, 1'b1, 1'b1, 1'b0);
      drive(1'b0, 1'b1, 32'h0000_0000, 32'h8000_0000, 2'd1);
      expect_lit("sub_minint", 32'h8000_0000, 1'b0, 1'b1, 1'b1, 1'b1);

      // logic ops never set carry/overflow
      drive(1'b0, 1'b1, 32'hF0F0_0000, 32'hFF00_00FF, 2'd2);
      expect_lit("and_neg", 32'hF000_0000, 1'b0, 1'b1, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'h0000_0000, 32'h0000_0000, 2'd3);
      expect_lit("or_zero", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);

      // reset wins over enable, then the first enabled edge is normal
      drive(1'b0, 1'b1, 32'hFFFF_FFFF, 32'd1, 2'd1);
      drive(1'b1, 1'b1, 32'd5001, 32'd3001, 2'd0);
      expect_lit("rst_priority", 32'd0, 1'b1, 1'b0, 1'b0, 1'b0);
      drive(1'b0, 1'b1, 32'd1, 32'd2, 2'd0);
      expect_lit("after_reset", 32'd3, 1'b0, 1'b0, 1'b0, 1'b0);

      // a short directed sweep that only the model checks
      for (int i = 0; i < 16; i++) begin
         drive(1'b0, (i % 5) != 3, 32'h1234_5678 * (i + 1), 32'h9ABC_DEF0 ^ (i << 28), i[1:0]);
      end

      drive(1'b0, 1'b0, 32'd0, 32'd0, 2'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
